alu_ctrl_muldiv: RTL and testbench

Next-generation ALU controller for the MIPS CPU datapath: keeps the single-cycle ALU control decode (ALUOp pass-through, R-type funct decode) and adds a multi-cycle multiply/divide unit with HI/LO registers. It sits between the main Decoder and the ALU/register-file writeback mux. It raises a stall to the pipeline front-end while an iterative MULT/DIV is in flight. Datapath width and iteration count are parametrised.

---
 rtl/alu_ctrl_pkg.sv | 45 ++++
 rtl/alu_ctrl_muldiv_core.sv | 63 ++++++
 rtl/alu_ctrl_muldiv.sv | 153 +++++++++++++++
 tb/tb_alu_ctrl_muldiv.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU controller and its multiply/divide unit:
// funct codes, ALU control codes, mul/div op and FSM state types.
package alu_ctrl_pkg;

    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_SLT   = 6'd42;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SLT  = 4'd4,
        ALU_SUB  = 4'd6,
        ALU_MFLO = 4'd13,
        ALU_MFHI = 4'd14,
        ALU_NOP  = 4'd15
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        MD_MULT,
        MD_MULTU,
        MD_DIV,
        MD_DIVU
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

    function automatic logic md_signed(md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/alu_ctrl_muldiv_core.sv
// Iterative magnitude datapath: shift-add multiply or restoring divide,
// one bit per step, sharing the hi/lo registers between both modes.
module muldiv_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              last
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] opnd;
    logic              div_mode;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   sh;
    logic [DATA_W:0]   diff;
    logic              ge;

    assign last = (cnt == CNT_W'(DATA_W - 1));

    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        sh   = {hi, lo[DATA_W-1]};
        diff = sh - {1'b0, opnd};
        ge   = (sh >= {1'b0, opnd});
    end

    // lo holds the multiplier (mul) or the dividend/quotient (div)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (load) begin
            cnt      <= '0;
            div_mode <= is_div;
            opnd     <= is_div ? b : a;
            lo       <= is_div ? a : b;
            hi       <= '0;
        end else if (step) begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (div_mode) begin
                hi <= ge ? diff[DATA_W-1:0] : sh[DATA_W-1:0];
                lo <= {lo[DATA_W-2:0], ge};
            end else begin
                hi <= sum[DATA_W:1];
                lo <= {sum[0], lo[DATA_W-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// ALU control decode plus multi-cycle MULT/DIV sequencing, HI/LO
// registers and front-end stall generation.
module alu_ctrl_muldiv
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 4,
    parameter int FUNCT_W = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [ALUOP_W-1:0] ALUOp_i,
    input  logic               valid_i,
    input  logic [DATA_W-1:0]  src1_i,
    input  logic [DATA_W-1:0]  src2_i,
    output logic [ALUOP_W-1:0] ALUCtrl_o,
    output logic               stall_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [DATA_W-1:0]  hi_o,
    output logic [DATA_W-1:0]  lo_o
);

    state_e    state;
    alu_ctrl_e ctrl;
    md_op_e    md_op;
    logic      is_md;
    logic      is_mf;
    logic      rtype;
    logic      start;
    logic      sgn;
    logic      is_div;
    logic      dz;
    logic      s1n;
    logic      s2n;

    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W-1:0] core_hi;
    logic [DATA_W-1:0] core_lo;
    logic              core_last;

    logic                is_div_q;
    logic                neg_q;
    logic                neg_r;
    logic                dz_q;
    logic [2*DATA_W-1:0] prod_s;

    always_comb begin
        ctrl  = ALU_NOP;
        md_op = MD_MULT;
        is_md = 1'b0;
        is_mf = 1'b0;
        unique case (funct_i)
            FUNCT_W'(F_ADD):   ctrl = ALU_ADD;
            FUNCT_W'(F_SUB):   ctrl = ALU_SUB;
            FUNCT_W'(F_AND):   ctrl = ALU_AND;
            FUNCT_W'(F_OR):    ctrl = ALU_OR;
            FUNCT_W'(F_SLT):   ctrl = ALU_SLT;
            FUNCT_W'(F_MFHI): begin
                ctrl  = ALU_MFHI;
                is_mf = 1'b1;
            end
            FUNCT_W'(F_MFLO): begin
                ctrl  = ALU_MFLO;
                is_mf = 1'b1;
            end
            FUNCT_W'(F_MULT):  begin md_op = MD_MULT;  is_md = 1'b1; end
            FUNCT_W'(F_MULTU): begin md_op = MD_MULTU; is_md = 1'b1; end
            FUNCT_W'(F_DIV):   begin md_op = MD_DIV;   is_md = 1'b1; end
            FUNCT_W'(F_DIVU):  begin md_op = MD_DIVU;  is_md = 1'b1; end
            default:           ctrl = ALU_NOP;
        endcase
    end

    assign rtype     = (ALUOp_i == {ALUOP_W{1'b1}});
    assign ALUCtrl_o = rtype ? ALUOP_W'(ctrl) : ALUOp_i;
    assign stall_o   = valid_i & rtype & (is_md | is_mf) & (state != IDLE);
    assign start     = valid_i & rtype & is_md & (state == IDLE);

    assign sgn    = md_signed(md_op);
    assign is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);
    assign dz     = is_div && (src2_i == '0);
    assign s1n    = sgn & src1_i[DATA_W-1];
    assign s2n    = sgn & src2_i[DATA_W-1];
    // on divide-by-zero the raw dividend rides through the core's lo register
    assign a_mag  = (s1n & ~dz) ? -src1_i : src1_i;
    assign b_mag  = s2n ? -src2_i : src2_i;
    assign prod_s = neg_q ? -{core_hi, core_lo} : {core_hi, core_lo};

    muldiv_core #(
        .DATA_W(DATA_W)
    ) u_core (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (start),
        .step   (state == RUN),
        .is_div (is_div),
        .a      (a_mag),
        .b      (b_mag),
        .hi     (core_hi),
        .lo     (core_lo),
        .last   (core_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            hi_o     <= '0;
            lo_o     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy_o   <= 1'b1;
                        is_div_q <= is_div;
                        dz_q     <= dz;
                        neg_q    <= ~dz & (s1n ^ s2n);
                        neg_r    <= ~dz & s1n;
                        state    <= dz ? FIX : RUN;
                    end
                end
                RUN: begin
                    if (core_last) state <= FIX;
                end
                FIX: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    if (dz_q) begin
                        hi_o <= core_lo;
                        lo_o <= '1;
                    end else if (is_div_q) begin
                        hi_o <= neg_r ? -core_hi : core_hi;
                        lo_o <= neg_q ? -core_lo : core_lo;
                    end else begin
                        {hi_o, lo_o} <= prod_s;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Scoreboard bench: stimulus pushes expected HI/LO and done timing,
// a monitor pops and checks on every done_o pulse.
module tb_alu_ctrl_muldiv;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          done_cyc;
        int          busy_len;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [5:0]  funct_i = '0;
    logic [3:0]  ALUOp_i = '0;
    logic        valid_i = 1'b0;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic [3:0]  ALUCtrl_o;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   busy_run = 0;
    exp_t sb[$];

    alu_ctrl_muldiv dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .funct_i   (funct_i),
        .ALUOp_i   (ALUOp_i),
        .valid_i   (valid_i),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .ALUCtrl_o (ALUCtrl_o),
        .stall_o   (stall_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // monitor: pops expected results on every done pulse
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i) begin
            busy_run = 0;
        end else begin
            if (busy_o) busy_run++;
            if (done_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_hi"}, 64'(hi_o), 64'(e.hi));
                    check({e.name, "_lo"}, 64'(lo_o), 64'(e.lo));
                    check({e.name, "_done_cyc"}, 64'(cyc), 64'(e.done_cyc));
                    check({e.name, "_busy_len"}, 64'(busy_run), 64'(e.busy_len));
                end
                busy_run = 0;
            end
        end
    end

    // caller sits at a negedge; start is accepted at the next posedge
    task automatic issue(input string name, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input int lat, input logic push);
        exp_t e;
        ALUOp_i = 4'hF;
        funct_i = f;
        src1_i  = a;
        src2_i  = b;
        valid_i = 1'b1;
        e.name     = name;
        e.hi       = ehi;
        e.lo       = elo;
        e.done_cyc = cyc + 1 + lat;
        e.busy_len = lat;
        if (push) sb.push_back(e);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit got;
        logic [5:0] fs [6];
        logic [3:0] cs [6];
        fs = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd63};
        cs = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd4, 4'd15};

        #1;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        ALUOp_i = 4'd2;
        funct_i = 6'd24;
        valid_i = 1'b1;
        #1;
        check("dec_pass", 64'(ALUCtrl_o), 64'd2);
        check("dec_pass_nostart", 64'(stall_o), 64'd0);
        ALUOp_i = 4'hF;
        for (int i = 0; i < 6; i++) begin
            funct_i = fs[i];
            #1;
            check($sformatf("dec_funct_%0d", fs[i]), 64'(ALUCtrl_o), 64'(cs[i]));
        end
        valid_i = 1'b0;

        @(negedge clk_i);
        issue("multu_max", 6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFE, 32'h00000001, 33, 1);
        check("multu_busy", 64'(busy_o), 64'd1);
        wait_done("multu_max");

        @(negedge clk_i);
        issue("div_m7_2", 6'd26, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1);
        wait_done("div_m7_2");

        @(negedge clk_i);
        issue("div_ovf", 6'd26, 32'h80000000, 32'hFFFFFFFF,
              32'h0, 32'h80000000, 33, 1);
        wait_done("div_ovf");

        @(negedge clk_i);
        issue("divu_zero", 6'd27, 32'd5, 32'd0,
              32'd5, 32'hFFFFFFFF, 1, 1);
        wait_done("divu_zero");

        @(negedge clk_i);
        issue("mult_6_m3", 6'd24, 32'd6, 32'hFFFFFFFD,
              32'hFFFFFFFF, 32'hFFFFFFEE, 33, 1);
        @(negedge clk_i);
        funct_i = 6'd32;
        valid_i = 1'b1;
        #1;
        check("busy_add_stall", 64'(stall_o), 64'd0);
        check("busy_add_ctrl", 64'(ALUCtrl_o), 64'd2);
        @(negedge clk_i);
        funct_i = 6'd18;
        #1;
        check("mflo_stall", 64'(stall_o), 64'd1);
        check("mflo_ctrl", 64'(ALUCtrl_o), 64'd13);
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                got = 1;
                break;
            end
            if (i % 10 == 0) check("mflo_stall_hold", 64'(stall_o), 64'd1);
        end
        check("mflo_done_seen", 64'(got), 64'd1);
        check("mflo_done_stall", 64'(stall_o), 64'd0);
        check("mflo_new_lo", 64'(lo_o), 64'hFFFFFFEE);
        issue("mult_b2b", 6'd24, 32'd7, 32'd8, 32'd0, 32'd56, 33, 1);
        check("b2b_busy", 64'(busy_o), 64'd1);
        wait_done("mult_b2b");

        @(negedge clk_i);
        issue("multu_abort", 6'd25, 32'd100, 32'd100, 32'd0, 32'd0, 33, 0);
        repeat (5) @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_done", 64'(done_o), 64'd0);
        check("mid_rst_hi", 64'(hi_o), 64'd0);
        check("mid_rst_lo", 64'(lo_o), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        issue("multu_3_4", 6'd25, 32'd3, 32'd4, 32'd0, 32'd12, 33, 1);
        wait_done("multu_3_4");

        repeat (3) @(negedge clk_i);
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("final_lo", 64'(lo_o), 64'd12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
